// File: rtl/seq_add_sub_64.sv
// seq_add_sub_64: multi-cycle WIDTH-bit add/subtract stage, one CHUNK-bit
// slice per clock with a registered carry between slices.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   out_valid / out_ready result handshake (sum, carry[, overflow, zero])
//   sub=0: a+b+cin ; sub=1: a-b (cin ignored), carry = no-borrow
//
// Optional: define OVF_ZERO_FLAGS_EN to add the overflow and zero outputs.
module seq_add_sub_64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef OVF_ZERO_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_sum_next;

`ifdef OVF_ZERO_FLAGS_EN
    logic r_ovf;
    logic r_zero;
    logic w_ovf;
`endif

    always_comb begin
        w_a_sl     = r_a[int'(r_k)*CHUNK +: CHUNK];
        w_b_sl     = r_b[int'(r_k)*CHUNK +: CHUNK];
        w_slice    = {1'b0, w_a_sl} + {1'b0, w_b_sl}
                   + {{CHUNK{1'b0}}, r_c};
        w_sum_next = r_sum;
        w_sum_next[int'(r_k)*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    end

`ifdef OVF_ZERO_FLAGS_EN
    // a^b^s at the MSB recovers the carry into the MSB; only meaningful
    // on the last slice, where slice bit CHUNK-1 is bit WIDTH-1.
    assign w_ovf = r_a[WIDTH-1] ^ r_b[WIDTH-1]
                 ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_k         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef OVF_ZERO_FLAGS_EN
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        // Subtraction as a + ~b + 1.
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub ? 1'b1 : cin;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum <= w_sum_next;
                    r_c   <= w_slice[CHUNK];
                    r_k   <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_carry     <= w_slice[CHUNK];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef OVF_ZERO_FLAGS_EN
                        r_ovf       <= w_ovf;
                        r_zero      <= (w_sum_next == '0);
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
`ifdef OVF_ZERO_FLAGS_EN
    assign overflow  = r_ovf;
    assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_seq_add_sub_64.sv
// tb_seq_add_sub_64: scoreboard bench for seq_add_sub_64.
// Define OVF_ZERO_FLAGS_EN to check the flag outputs too.
module tb_seq_add_sub_64;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        carry;
`ifdef OVF_ZERO_FLAGS_EN
    logic        overflow;
    logic        zero;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_add_sub_64 #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef OVF_ZERO_FLAGS_EN
        ,
        .overflow  (overflow),
        .zero      (zero)
`endif
    );

    function automatic exp_t model(input logic [63:0] a_, input logic [63:0] b_,
                                   input logic cin_, input logic sub_);
        logic [63:0] be;
        logic [64:0] r;
        exp_t        e;
        be  = sub_ ? ~b_ : b_;
        r   = {1'b0, a_} + {1'b0, be} + {64'd0, (sub_ ? 1'b1 : cin_)};
        e.s = r[63:0];
        e.c = r[64];
        e.v = (a_[63] == be[63]) && (r[63] != a_[63]);
        e.z = (r[63:0] == 64'd0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] s_, input logic c_,
                                input logic v_, input logic z_);
        exp_t e;
        e.s = s_; e.c = c_; e.v = v_; e.z = z_;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [63:0] a_, input logic [63:0] b_,
                            input logic cin_, input logic sub_, output bit ok);
        a = a_; b = b_; cin = cin_; sub = sub_;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 64'h1; b = 64'h1; cin = 1'b0; sub = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || sum !== 64'd0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b s=%h c=%b want 0", out_valid, sum, carry);
        end
`ifdef OVF_ZERO_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got o=%b z=%b want 0", overflow, zero);
        end
`endif
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        ok = 1'b1;
    endtask

    task automatic test_add();
        logic [63:0] ta [3];
        logic [63:0] tb [3];
        logic        tc [3];
        exp_t        te [3];
        exp_t        e;
        bit          ok;
        ta[0] = 64'h123456789ABCDEF0; tb[0] = 64'h0FEDCBA987654321; tc[0] = 1'b1;
        te[0] = mk(64'h2222222222222212, 1'b0, 1'b0, 1'b0);
        ta[1] = 64'hFFFFFFFFFFFFFFFF; tb[1] = 64'h1; tc[1] = 1'b0;
        te[1] = mk(64'h0, 1'b1, 1'b0, 1'b1);
        ta[2] = 64'hFFFFFFFFFFFFFFFF; tb[2] = 64'hFFFFFFFFFFFFFFFF; tc[2] = 1'b1;
        te[2] = mk(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(te[i]);
            drive_op(ta[i], tb[i], tc[i], 1'b0, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL add[%0d]_accept timeout", i);
            end
            if (i == 0) begin
                tick(); tick(); tick();
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early got v=%b want 0 after 3 edges", out_valid);
                end
                tick();
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency got v=%b want 1 after 4 edges", out_valid);
                end
            end
            wait_out(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || sum !== e.s || carry !== e.c) begin
                errors++;
                $display("FAIL add[%0d] got v=%b s=%h c=%b want s=%h c=%b",
                         i, out_valid, sum, carry, e.s, e.c);
            end
`ifdef OVF_ZERO_FLAGS_EN
            checks++;
            if (overflow !== e.v || zero !== e.z) begin
                errors++;
                $display("FAIL add[%0d]_flags got o=%b z=%b want o=%b z=%b",
                         i, overflow, zero, e.v, e.z);
            end
`endif
            handshake();
        end
    endtask

    task automatic test_sub();
        exp_t e;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) sb.push_back(mk(64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0));
            else        sb.push_back(mk(64'h2, 1'b1, 1'b0, 1'b0));
            drive_op(i == 0 ? 64'd5 : 64'd7, i == 0 ? 64'd7 : 64'd5, 1'b1, 1'b1, ok);
            // Inputs changing after acceptance must not matter.
            a = 64'hDEAD; b = 64'hBEEF; sub = 1'b0; cin = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sub[%0d]_accept timeout", i);
            end
            wait_out(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || sum !== e.s || carry !== e.c) begin
                errors++;
                $display("FAIL sub[%0d] got v=%b s=%h c=%b want s=%h c=%b",
                         i, out_valid, sum, carry, e.s, e.c);
            end
`ifdef OVF_ZERO_FLAGS_EN
            checks++;
            if (overflow !== e.v || zero !== e.z) begin
                errors++;
                $display("FAIL sub[%0d]_flags got o=%b z=%b want o=%b z=%b",
                         i, overflow, zero, e.v, e.z);
            end
`endif
            handshake();
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        bit   ok;
        sb.push_back(mk(64'h8000000000000000, 1'b0, 1'b1, 1'b0));
        drive_op(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, ok);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || sum !== e.s || carry !== e.c) begin
            errors++;
            $display("FAIL ovf got v=%b s=%h c=%b want s=%h c=%b",
                     out_valid, sum, carry, e.s, e.c);
        end
`ifdef OVF_ZERO_FLAGS_EN
        checks++;
        if (overflow !== e.v || zero !== e.z) begin
            errors++;
            $display("FAIL ovf_flags got o=%b z=%b want o=%b z=%b", overflow, zero, e.v, e.z);
        end
`endif
        handshake();
    endtask

    task automatic test_backpressure();
        exp_t        e;
        bit          ok;
        logic [63:0] s0;
        logic        c0;
        sb.push_back(model(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b0));
        drive_op(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b0, ok);
        wait_out(ok);
        s0 = sum; c0 = carry;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== s0 || carry !== c0) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b rdy=%b s=%h c=%b want v=1 rdy=0 s=%h c=%b",
                         i, out_valid, in_ready, sum, carry, s0, c0);
            end
        end
        e = sb.pop_front();
        checks++;
        if (!ok || sum !== e.s || carry !== e.c) begin
            errors++;
            $display("FAIL bp_result got s=%h c=%b want s=%h c=%b", sum, carry, e.s, e.c);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        sb.push_back(model(64'h00000000FFFFFFFF, 64'h0000000000000001, 1'b0, 1'b0));
        sb.push_back(model(64'h1000000000000000, 64'h0000000000000003, 1'b0, 1'b1));
        drive_op(64'h00000000FFFFFFFF, 64'h0000000000000001, 1'b0, 1'b0, ok);
        a = 64'h1000000000000000; b = 64'h3; cin = 1'b0; sub = 1'b1;
        in_valid = 1'b1;
        wait_out(ok);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy got rdy=%b want 0", in_ready);
        end
        e = sb.pop_front();
        checks++;
        if (!ok || sum !== e.s || carry !== e.c) begin
            errors++;
            $display("FAIL b2b_first got s=%h c=%b want s=%h c=%b", sum, carry, e.s, e.c);
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        drive_op(64'h1000000000000000, 64'h3, 1'b0, 1'b1, ok);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || sum !== e.s || carry !== e.c) begin
            errors++;
            $display("FAIL b2b_second got v=%b s=%h c=%b want s=%h c=%b",
                     out_valid, sum, carry, e.s, e.c);
        end
        handshake();
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bit   ok;
        bit   seen;
        drive_op(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0, 1'b0, ok);
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rdy got rdy=%b want 0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 64'd0 || carry !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got v=%b s=%h c=%b rdy=%b want 0 0 0 1",
                     out_valid, sum, carry, in_ready);
        end
`ifdef OVF_ZERO_FLAGS_EN
        checks++;
        if (overflow !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags got o=%b z=%b want 0", overflow, zero);
        end
`endif
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_no_valid got pulse=1 want 0");
        end
        sb.push_back(mk(64'd2, 1'b0, 1'b0, 1'b0));
        drive_op(64'd1, 64'd1, 1'b0, 1'b0, ok);
        wait_out(ok);
        e = sb.pop_front();
        checks++;
        if (!ok || sum !== e.s || carry !== e.c) begin
            errors++;
            $display("FAIL midrst_next got v=%b s=%h c=%b want s=%h c=%b",
                     out_valid, sum, carry, e.s, e.c);
        end
        handshake();
    endtask

    task automatic test_random();
        exp_t        e;
        bit          ok;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(1));
            rs = 1'($urandom_range(1));
            sb.push_back(model(ra, rb, rc, rs));
            drive_op(ra, rb, rc, rs, ok);
            wait_out(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || sum !== e.s || carry !== e.c) begin
                errors++;
                $display("FAIL rnd[%0d] got v=%b s=%h c=%b want s=%h c=%b",
                         i, out_valid, sum, carry, e.s, e.c);
            end
`ifdef OVF_ZERO_FLAGS_EN
            checks++;
            if (overflow !== e.v || zero !== e.z) begin
                errors++;
                $display("FAIL rnd[%0d]_flags got o=%b z=%b want o=%b z=%b",
                         i, overflow, zero, e.v, e.z);
            end
`endif
            handshake();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_add_sub_64.md
Name: seq_add_sub_64

Overview:
- Multi-cycle 64-bit add/subtract execution stage.
- Sits directly in front of the downstream result consumer; replaces the single-cycle 64-bit ripple-carry path where timing forbids a full 64-bit carry chain.
- Accepts operands over a valid/ready handshake and computes the result over several clock cycles, one CHUNK-bit slice per cycle. A registered carry is passed between slices.
- Presents sum, carry and flags over a valid/ready output handshake.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, bits added per cycle. WIDTH must be an integer multiple of CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  stage can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- carry  output  1  carry-out of bit WIDTH-1. For subtraction this is the no-borrow flag: 1 means A>=B unsigned.
- overflow  output  1  signed overflow. Present only with OVF_ZERO_FLAGS_EN.
- zero  output  1  sum==0. Present only with OVF_ZERO_FLAGS_EN.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
  - out_valid=0, sum=0, carry=0, overflow=0, zero=0.
  - Internal chunk counter and carry register cleared.
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid=1, capture A and B_eff (B if sub=0, ~B if sub=1), and set carry_reg (cin if sub=0, 1 if sub=1). Move to RUN with k=0.
  - RUN:
    - in_ready=0.
    - Each cycle, add slice k of A, B_eff and carry_reg in a CHUNK-bit ripple adder. Write the slice into sum bits [k*CHUNK +: CHUNK] and update carry_reg.
    - k increments each cycle. After slice WIDTH/CHUNK-1, go to DONE.
  - DONE:
    - out_valid=1; sum, carry and flags are stable.
    - Hold until out_ready=1, then go to IDLE.
- Latency: with the defaults, the accepting edge is edge 0 and out_valid rises after edge 4, i.e. WIDTH/CHUNK edges after acceptance.
- Throughput: one operation per WIDTH/CHUNK+2 cycles with out_ready held high. The result handshake and a new operand acceptance cannot occur in the same cycle.
- Arithmetic:
  - Everything is modulo 2^WIDTH.
  - The final carry_reg drives carry.
  - The sub/cin value captured at acceptance is used throughout. Input changes after acceptance are ignored.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold unchanged indefinitely.
- Operands presented in RUN or DONE: in_ready=0, nothing is captured, and the upstream must hold in_valid.
- Reset mid-operation: rst in RUN or DONE aborts the operation. The result is discarded and the block returns to IDLE with reset values; no out_valid pulse is produced.
- in_valid=1 in the same cycle as rst: ignored.
- Partial results: sum bits of not-yet-computed slices are not guaranteed before out_valid=1.

Optional Feature:
- Macro: OVF_ZERO_FLAGS_EN.
- When defined:
  - overflow and zero ports exist and are registered with the final slice.
  - overflow = carry into MSB XOR carry out of MSB, valid for both add and sub.
  - zero = (sum==0).
  - Both are valid and held while out_valid=1; both reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Add with carry-in: a=0x123456789ABCDEF0, b=0x0FEDCBA987654321, cin=1, sub=0 -> after 4 edges out_valid=1, sum=0x2222222222222212, carry=0.
- Full wrap: a=0xFFFFFFFFFFFFFFFF, b=0x1, cin=0 -> sum=0, carry=1, zero=1 (flags build). Also a=b=0xFFFFFFFFFFFFFFFF, cin=1 -> sum=0xFFFFFFFFFFFFFFFF, carry=1.
- Subtract: a=5, b=7, sub=1, cin=1 (must be ignored) -> sum=0xFFFFFFFFFFFFFFFE, carry=0. Also a=7, b=5 -> sum=2, carry=1.
- Signed overflow (flags build): a=0x7FFFFFFFFFFFFFFF, b=0x1, sub=0 -> sum=0x8000000000000000, carry=0, overflow=1.
- Backpressure and handshake: hold out_ready=0 for 3 cycles after out_valid -> sum/carry stable and in_ready=0 throughout. A second in_valid held during RUN/DONE is accepted only after the out handshake, and its result is correct.
- Reset mid-op: assert rst for 1 cycle at k=2 of a 0xAAAA…AAAA+0x5555…5555 op -> no out_valid, all outputs 0, in_ready=1 in the cycle after rst. The next op (1+1) returns sum=2.
